bitcell_array_ctrl: RTL

- Synchronous sequencer that sits directly upstream of a DEPTH x WIDTH array of Bitcell_NAND latches.
- Accepts word-level read/write requests from a host over a valid/ready handshake.
- Drives the cells' sel / r_w / in pins with a glitch-safe setup, pulse and hold sequence.
- Captures the cells' tri-stated out bus on reads and returns it with a one-cycle response strobe.

---
 rtl/bitcell_array_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bitcell_array_ctrl.sv
// Sequencer for a DEPTH x WIDTH array of Bitcell_NAND latches: host valid/ready requests in,
// glitch-safe setup/pulse/hold on sel/r_w/in, captured read data out with a one-cycle strobe.
module bitcell_array_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [DEPTH-1:0] cell_sel,
    output logic             cell_rw,
    output logic [WIDTH-1:0] cell_in,
    input  logic [WIDTH-1:0] cell_out
);

    localparam int unsigned CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state_q, state_n;
    logic              we_q, we_n;
    logic [AW-1:0]     addr_q, addr_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              ready_n;
    logic              rsp_valid_n;
    logic [WIDTH-1:0]  rsp_rdata_n;
    logic              rsp_err_n;
    logic [DEPTH-1:0]  sel_n;
    logic              rw_n;
    logic [WIDTH-1:0]  in_n;
    logic              addr_ok_c;

    assign addr_ok_c = (32'(addr_q) < DEPTH);

    // State and registered-output update; async reset drops sel at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cell_sel  <= '0;
            cell_rw   <= 1'b0;
            cell_in   <= '0;
        end else begin
            state_q   <= state_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            cnt_q     <= cnt_n;
            req_ready <= ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            cell_sel  <= sel_n;
            cell_rw   <= rw_n;
            cell_in   <= in_n;
        end
    end

    // Next state and next output values; rw/in only move while sel is low
    always_comb begin
        state_n     = state_q;
        we_n        = we_q;
        addr_n      = addr_q;
        cnt_n       = cnt_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        sel_n       = '0;
        rw_n        = cell_rw;
        in_n        = cell_in;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_n = SETUP;
                    we_n    = req_we;
                    addr_n  = req_addr;
                    rw_n    = req_we;
                    if (req_we) begin
                        in_n = req_wdata;
                    end
                end
            end
            SETUP: begin
                if (addr_ok_c) begin
                    state_n = PULSE;
                    sel_n   = DEPTH'(1) << addr_q;
                    cnt_n   = '0;
                end else begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_n = HOLD;
                    if (!we_q) begin
                        rsp_rdata_n = cell_out;
                    end
                end else begin
                    sel_n = cell_sel;
                    cnt_n = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
            end
            RESP: begin
                state_n = IDLE;
                rw_n    = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule
